// File: rtl/ssd_pkg.sv
// ---------------------------------------------------------------------------
// ssd_pkg
// Shared seven-segment symbol definitions. The lock controller builds its
// display word from these 5-bit symbol codes, and the scan driver decodes
// them. Codes 0x00-0x0F are plain hex digits ({1'b0, nibble}), so switch
// nibbles can be shown without translation.
// ---------------------------------------------------------------------------
package ssd_pkg;

    localparam int DIGITS = 4;

    typedef logic [4:0] symCode_t;
    typedef logic [6:0] segPattern_t;

    localparam symCode_t SYM_0     = 5'h00;
    localparam symCode_t SYM_1     = 5'h01;
    localparam symCode_t SYM_2     = 5'h02;
    localparam symCode_t SYM_3     = 5'h03;
    localparam symCode_t SYM_4     = 5'h04;
    localparam symCode_t SYM_5     = 5'h05;
    localparam symCode_t SYM_6     = 5'h06;
    localparam symCode_t SYM_7     = 5'h07;
    localparam symCode_t SYM_8     = 5'h08;
    localparam symCode_t SYM_9     = 5'h09;
    localparam symCode_t SYM_A     = 5'h0A;
    localparam symCode_t SYM_B     = 5'h0B;
    localparam symCode_t SYM_C     = 5'h0C;
    localparam symCode_t SYM_D     = 5'h0D;
    localparam symCode_t SYM_E     = 5'h0E;
    localparam symCode_t SYM_F     = 5'h0F;
    localparam symCode_t SYM_BLANK = 5'h10;
    localparam symCode_t SYM_L     = 5'h11;
    localparam symCode_t SYM_DLOW  = 5'h12;
    localparam symCode_t SYM_P     = 5'h13;
    localparam symCode_t SYM_NLOW  = 5'h14;
    localparam symCode_t SYM_DASH  = 5'h15;

    // All segments dark (active-low outputs).
    localparam segPattern_t SEG_OFF = 7'b1111111;

endpackage

// File: rtl/ssd_code_decoder.sv
// ---------------------------------------------------------------------------
// ssd_code_decoder
// Purely combinational: maps a 5-bit symbol code to the active-low segment
// pattern {g,f,e,d,c,b,a} for a common-anode digit. Unused codes show blank.
//   i_code  in   5  symbol code
//   o_seg   out  7  active-low segments {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
module ssd_code_decoder
    import ssd_pkg::*;
(
    input  logic [4:0] i_code,
    output logic [6:0] o_seg
);

    // Symbol lookup; anything outside the defined set falls to blank.
    always_comb begin
        o_seg = SEG_OFF;
        case (i_code)
            SYM_0:     o_seg = 7'b1000000;
            SYM_1:     o_seg = 7'b1111001;
            SYM_2:     o_seg = 7'b0100100;
            SYM_3:     o_seg = 7'b0110000;
            SYM_4:     o_seg = 7'b0011001;
            SYM_5:     o_seg = 7'b0010010;
            SYM_6:     o_seg = 7'b0000010;
            SYM_7:     o_seg = 7'b1111000;
            SYM_8:     o_seg = 7'b0000000;
            SYM_9:     o_seg = 7'b0010000;
            SYM_A:     o_seg = 7'b0001000;
            SYM_B:     o_seg = 7'b0000011;
            SYM_C:     o_seg = 7'b1000110;
            SYM_D:     o_seg = 7'b0100001;
            SYM_E:     o_seg = 7'b0000110;
            SYM_F:     o_seg = 7'b0001110;
            SYM_BLANK: o_seg = SEG_OFF;
            SYM_L:     o_seg = 7'b1000111;
            SYM_DLOW:  o_seg = 7'b0100001;
            SYM_P:     o_seg = 7'b0001100;
            SYM_NLOW:  o_seg = 7'b0101011;
            SYM_DASH:  o_seg = 7'b0111111;
            default:   o_seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/ssd_scan_driver.sv
// ---------------------------------------------------------------------------
// ssd_scan_driver
// Time-multiplexed driver for a four-digit common-anode display. Digits are
// lit one at a time for REFRESH_DIV cycles each; a free-running blink timer
// blanks digits selected by the blink mask every other BLINK_DIV cycles.
// The display word and mask are captured once per frame so a digit never
// shows a mix of old and new data.
//   clk         in   1   system clock
//   rst         in   1   asynchronous active-high reset
//   ssd         in   20  four symbol codes, [19:15] leftmost
//   blink_mask  in   4   bit i set -> digit on an[i] blinks
//   en          in   1   display enable (0 turns all anodes off)
//   an          out  4   active-low anode selects, an[3] leftmost
//   seg         out  7   active-low segments {g,f,e,d,c,b,a}
//   dp          out  1   active-low decimal point, held off
// ---------------------------------------------------------------------------
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int REFRESH_DIV = 50_000,
    parameter int BLINK_DIV   = 25_000_000
)(
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] ssd,
    input  logic [3:0]  blink_mask,
    input  logic        en,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [RW-1:0] r_refreshCnt;
    logic [BW-1:0] r_blinkCnt;
    logic [1:0]    r_idx;
    logic          r_blinkOn;
    logic [19:0]   r_shadowSsd;
    logic [3:0]    r_shadowMask;
    logic [3:0]    r_an;
    logic [6:0]    r_seg;

    logic          w_refreshTc;
    logic [3:0]    w_anSel;
    logic          w_maskBit;
    logic [4:0]    w_code;
    logic [6:0]    w_decSeg;

    assign w_refreshTc = (r_refreshCnt == REF_LAST);
    // Index 0 is the leftmost digit, which sits on an[3].
    assign w_anSel     = 4'b1000 >> r_idx;
    assign w_maskBit   = |(r_shadowMask & w_anSel);

    // Pick the shadow symbol belonging to the digit currently being scanned.
    always_comb begin
        w_code = r_shadowSsd[19:15];
        case (r_idx)
            2'd0: w_code = r_shadowSsd[19:15];
            2'd1: w_code = r_shadowSsd[14:10];
            2'd2: w_code = r_shadowSsd[9:5];
            2'd3: w_code = r_shadowSsd[4:0];
            default: w_code = r_shadowSsd[19:15];
        endcase
    end

    ssd_code_decoder u_decoder (
        .i_code (w_code),
        .o_seg  (w_decSeg)
    );

    // Digit scan: the refresh counter paces the digit index. Leaving the last
    // digit is also the frame boundary, the only moment inputs are captured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_refreshCnt <= '0;
            r_idx        <= 2'd0;
            r_shadowSsd  <= {DIGITS{SYM_BLANK}};
            r_shadowMask <= 4'b0000;
        end else if (w_refreshTc) begin
            r_refreshCnt <= '0;
            r_idx        <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
                r_shadowSsd  <= ssd;
                r_shadowMask <= blink_mask;
            end
        end else begin
            r_refreshCnt <= r_refreshCnt + RW'(1);
        end
    end

    // Blink timer runs free of the scan so blink rate is independent of frames.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blinkCnt <= '0;
            r_blinkOn  <= 1'b1;
        end else if (r_blinkCnt == BLINK_LAST) begin
            r_blinkCnt <= '0;
            r_blinkOn  <= ~r_blinkOn;
        end else begin
            r_blinkCnt <= r_blinkCnt + BW'(1);
        end
    end

    // Output registers keep the pins glitch-free; they trail the scan state
    // by one cycle. A disabled display or a blinked-off digit goes dark.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an  <= 4'b1111;
            r_seg <= SEG_OFF;
        end else if (!en) begin
            r_an  <= 4'b1111;
            r_seg <= SEG_OFF;
        end else begin
            r_an  <= ~w_anSel;
            r_seg <= (w_maskBit && !r_blinkOn) ? SEG_OFF : w_decSeg;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = 1'b1;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_ssd_scan_driver
// Self-checking bench for the scan driver with REFRESH_DIV=4, BLINK_DIV=16.
// The reference model works from elapsed cycle count: digit index, blink
// phase and frame boundaries are derived with division/modulo, and the
// captured frame is held in a pair of model variables.
// ---------------------------------------------------------------------------
module tb_ssd_scan_driver;

    localparam int RD = 4;
    localparam int BD = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] ssd;
    logic [3:0]  blink_mask;
    logic        en;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int compared   = 0;
    int mismatched = 0;
    int n;
    logic [19:0] shSsd;
    logic [3:0]  shMask;
    logic [6:0]  segRef [32];

    ssd_scan_driver #(
        .REFRESH_DIV (RD),
        .BLINK_DIV   (BD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ssd        (ssd),
        .blink_mask (blink_mask),
        .en         (en),
        .an         (an),
        .seg        (seg),
        .dp         (dp)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [6:0] observed,
                               input logic [6:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s cycle %0d: got %b, expected %b",
                     tag, n, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [19:0] s, input logic [3:0] m,
                                 input logic e);
        ssd        = s;
        blink_mask = m;
        en         = e;
    endtask

    task automatic modelReset();
        n      = 0;
        shSsd  = {4{5'h10}};
        shMask = 4'b0000;
    endtask

    // One clock: predict the outputs for edge n from the state after n-1
    // edges, update the captured frame on frame boundaries, then check.
    task automatic stepCycle();
        int         m;
        int         idx;
        bit         blinkOn;
        logic [4:0] code;
        logic [3:0] expAn;
        logic [6:0] expSeg;
        @(posedge clk);
        n++;
        m       = n - 1;
        idx     = (m / RD) % 4;
        blinkOn = ((m / BD) % 2) == 0;
        code    = 5'((shSsd >> (5 * (3 - idx))) & 20'h1F);
        if (!en) begin
            expAn  = 4'b1111;
            expSeg = 7'b1111111;
        end else begin
            expAn  = ~(4'b0001 << (3 - idx));
            expSeg = (shMask[3 - idx] && !blinkOn) ? 7'b1111111 : segRef[code];
        end
        if (n % (4 * RD) == 0) begin
            shSsd  = ssd;
            shMask = blink_mask;
        end
        @(negedge clk);
        checkOutput("an", {3'b000, an}, {3'b000, expAn});
        checkOutput("seg", seg, expSeg);
        checkOutput("dp", {6'b0, dp}, 7'd1);
    endtask

    task automatic runCycles(input int k);
        for (int i = 0; i < k; i++) stepCycle();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) segRef[i] = 7'b1111111;
        segRef[0]  = 7'b1000000; segRef[1]  = 7'b1111001;
        segRef[2]  = 7'b0100100; segRef[3]  = 7'b0110000;
        segRef[4]  = 7'b0011001; segRef[5]  = 7'b0010010;
        segRef[6]  = 7'b0000010; segRef[7]  = 7'b1111000;
        segRef[8]  = 7'b0000000; segRef[9]  = 7'b0010000;
        segRef[10] = 7'b0001000; segRef[11] = 7'b0000011;
        segRef[12] = 7'b1000110; segRef[13] = 7'b0100001;
        segRef[14] = 7'b0000110; segRef[15] = 7'b0001110;
        segRef[16] = 7'b1111111; segRef[17] = 7'b1000111;
        segRef[18] = 7'b0100001; segRef[19] = 7'b0001100;
        segRef[20] = 7'b0101011; segRef[21] = 7'b0111111;

        rst = 1'b1;
        applyStimulus({5'h0C, 5'h11, 5'h05, 5'h12}, 4'b0000, 1'b1);
        modelReset();
        repeat (2) @(negedge clk);
        checkOutput("rstAn", {3'b000, an}, 7'b0001111);
        checkOutput("rstSeg", seg, 7'b1111111);
        rst = 1'b0;

        // Blank first frame, then {C,L,5,d}.
        runCycles(38);
        // Mid-frame change must wait for the next frame boundary.
        applyStimulus({5'h01, 5'h02, 5'h03, 5'h04}, 4'b0000, 1'b1);
        runCycles(26);
        // Leftmost digit blinking.
        applyStimulus({5'h07, 5'h10, 5'h10, 5'h10}, 4'b1000, 1'b1);
        runCycles(64);
        // Display disabled for 10 cycles, then resumes without restart.
        applyStimulus({5'h07, 5'h10, 5'h10, 5'h10}, 4'b1000, 1'b0);
        runCycles(10);
        applyStimulus({5'h07, 5'h10, 5'h10, 5'h10}, 4'b1000, 1'b1);
        runCycles(20);
        // Out-of-range code in the rightmost digit.
        applyStimulus({5'h08, 5'h03, 5'h0A, 5'h1F}, 4'b0000, 1'b1);
        runCycles(32);

        // Random words, masks and enable drops.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(20'($urandom), 4'($urandom), 1'($urandom_range(0, 9) != 0));
            stepCycle();
        end

        // Reach index 2 with blink_on low, then reset asynchronously.
        applyStimulus({5'h13, 5'h0E, 5'h15, 5'h14}, 4'b1111, 1'b1);
        for (int g = 0; g < 100; g++) begin
            if (((n / RD) % 4 == 2) && ((n / BD) % 2 == 1)) break;
            stepCycle();
        end
        rst = 1'b1;
        #1;
        checkOutput("midRstAn", {3'b000, an}, 7'b0001111);
        checkOutput("midRstSeg", seg, 7'b1111111);
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        runCycles(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
